// File: rtl/npu_host_pkg.sv
// Shared constants for the atomNPU host link: FSM encodings, pin-bit positions
// and the sizing helper for the shared duration timer.
package npu_host_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RSTHOLD = 3'd0;
  localparam state_t ST_IDLE    = 3'd1;
  localparam state_t ST_DRIVE   = 3'd2;
  localparam state_t ST_GAP     = 3'd3;
  localparam state_t ST_START   = 3'd4;
  localparam state_t ST_WAIT    = 3'd5;
  localparam state_t ST_RESULT  = 3'd6;

  localparam int STROBE_BIT = 0;
  localparam int START_BIT  = 1;
  localparam int RVALID_BIT = 2;

  // The timer is loaded with (duration-1), so it must hold the largest duration minus one.
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/npu_host_link_if.sv
// Operand stream (s_*) and result stream (m_*) of the NPU host link.
interface npu_host_link_if;

  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_timeout;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_timeout
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_timeout
  );

endinterface

// File: rtl/npu_host_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module npu_host_timer #(
  parameter int           W       = 11,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/npu_host_link.sv
// Host-side sequencer for the atomNPU pins: serialises operand bytes with a load
// strobe, pulses start, then returns the NPU result byte (or a timeout) on m_*.
module npu_host_link
  import npu_host_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1,
  parameter int TIMEOUT       = 1024,
  parameter int MAX_BYTES     = 16,
  parameter int RST_HOLD      = 4
) (
  input  logic            clk,
  input  logic            rst,
  npu_host_link_if.slave  link,
  output logic            busy,
  output logic [7:0]      npu_ui_in,
  output logic [7:0]      npu_uio_in,
  input  logic [7:0]      npu_uo_out,
  input  logic [7:0]      npu_uio_out,
  output logic            npu_ena,
  output logic            npu_rst_n
);

  localparam int TW = timer_width(STROBE_CYCLES, GAP_CYCLES, TIMEOUT, RST_HOLD);
  localparam int BW = $clog2(MAX_BYTES + 1);

  state_t        state;
  state_t        state_next;
  logic [BW-1:0] byte_cnt;
  logic          last;
  logic          ena;
  logic [7:0]    operand;
  logic [7:0]    result;
  logic          timeout_flag;
  logic          accept;
  logic          rvalid;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_expired;
  logic          unused_pins;

  assign accept      = (state == ST_IDLE) && link.s_valid;
  assign rvalid      = npu_uio_out[RVALID_BIT];
  assign unused_pins = ^{npu_uio_out[7:3], npu_uio_out[1:0]};

  // One timer covers reset hold, strobe, gap and the result wait; it comes out
  // of reset already loaded for the reset hold.
  npu_host_timer #(
    .W       (TW),
    .RST_VAL (TW'(RST_HOLD - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      ST_RSTHOLD: if (tmr_expired) state_next = ST_IDLE;
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_DRIVE;
          tmr_load   = 1'b1;
          tmr_val    = TW'(STROBE_CYCLES - 1);
        end
      end
      ST_DRIVE: begin
        if (tmr_expired) begin
          state_next = ST_GAP;
          tmr_load   = 1'b1;
          tmr_val    = TW'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: if (tmr_expired) state_next = last ? ST_START : ST_IDLE;
      ST_START: begin
        state_next = ST_WAIT;
        tmr_load   = 1'b1;
        tmr_val    = TW'(TIMEOUT - 1);
      end
      ST_WAIT:   if (rvalid || tmr_expired) state_next = ST_RESULT;
      ST_RESULT: if (link.m_ready) state_next = ST_IDLE;
      default:   state_next = ST_RSTHOLD;
    endcase
  end

  // A result_valid in the final wait cycle wins over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RSTHOLD;
      ena          <= 1'b0;
      operand      <= '0;
      last         <= 1'b0;
      byte_cnt     <= '0;
      result       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_RSTHOLD: if (tmr_expired) ena <= 1'b1;
        ST_IDLE: begin
          if (accept) begin
            operand  <= link.s_data;
            last     <= link.s_last || (byte_cnt == BW'(MAX_BYTES - 1));
            byte_cnt <= byte_cnt + BW'(1);
          end
        end
        ST_START: byte_cnt <= '0;
        ST_WAIT: begin
          if (rvalid) begin
            result       <= npu_uo_out;
            timeout_flag <= 1'b0;
          end else if (tmr_expired) begin
            result       <= '0;
            timeout_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    npu_uio_in             = '0;
    npu_uio_in[STROBE_BIT] = (state == ST_DRIVE);
    npu_uio_in[START_BIT]  = (state == ST_START);
  end

  assign link.s_ready   = (state == ST_IDLE);
  assign link.m_valid   = (state == ST_RESULT);
  assign link.m_data    = result;
  assign link.m_timeout = timeout_flag;
  assign busy           = (state != ST_IDLE);
  assign npu_ui_in      = operand;
  assign npu_ena        = ena;
  assign npu_rst_n      = ena;

endmodule

// File: tb/tb_npu_host_link.sv
// Directed bench for npu_host_link: pin monitor, behavioural NPU responder and
// a result scoreboard checked with immediate assertions.
module tb_npu_host_link;

  localparam int STROBE_CYCLES = 2;
  localparam int GAP_CYCLES    = 1;
  localparam int TIMEOUT       = 1024;
  localparam int MAX_BYTES     = 16;
  localparam int RST_HOLD      = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       timeout;
  } result_t;

  typedef struct {
    int         len;
    logic [7:0] data;
    logic       stable;
  } strobe_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [7:0] npu_ui_in;
  logic [7:0] npu_uio_in;
  logic [7:0] npu_uo_out;
  logic [7:0] npu_uio_out;
  logic       npu_ena;
  logic       npu_rst_n;

  npu_host_link_if link ();

  npu_host_link #(
    .STROBE_CYCLES (STROBE_CYCLES),
    .GAP_CYCLES    (GAP_CYCLES),
    .TIMEOUT       (TIMEOUT),
    .MAX_BYTES     (MAX_BYTES),
    .RST_HOLD      (RST_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .link        (link),
    .busy        (busy),
    .npu_ui_in   (npu_ui_in),
    .npu_uio_in  (npu_uio_in),
    .npu_uo_out  (npu_uo_out),
    .npu_uio_out (npu_uio_out),
    .npu_ena     (npu_ena),
    .npu_rst_n   (npu_rst_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  result_t exp_q[$];
  strobe_t strobe_q[$];
  int      gap_q[$];

  // Pin monitor: strobe runs, gaps between strobes of one command, start pulses, handshakes.
  logic       in_strobe = 1'b0;
  logic       have_prev = 1'b0;
  int         run_len = 0;
  logic [7:0] run_data = '0;
  logic       run_stable = 1'b1;
  int         low_len = 0;
  int         strobe_total = 0;
  int         start_cnt = 0;
  int         start_cyc = 0;
  int         strobes_at_start = 0;
  int         hs_total = 0;
  int         hs_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_strobe <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      if (npu_uio_in[0]) begin
        if (!in_strobe) begin
          run_len    <= 1;
          run_data   <= npu_ui_in;
          run_stable <= 1'b1;
          if (have_prev) gap_q.push_back(low_len);
        end else begin
          run_len <= run_len + 1;
          if (npu_ui_in !== run_data) run_stable <= 1'b0;
        end
        in_strobe <= 1'b1;
        low_len   <= 0;
      end else begin
        if (in_strobe) begin
          strobe_q.push_back('{run_len, run_data, run_stable});
          strobe_total <= strobe_total + 1;
          have_prev    <= 1'b1;
          low_len      <= 1;
        end else begin
          low_len <= low_len + 1;
        end
        in_strobe <= 1'b0;
      end
      if (npu_uio_in[1]) begin
        start_cnt        <= start_cnt + 1;
        start_cyc        <= cyc;
        strobes_at_start <= strobe_total;
        have_prev        <= 1'b0;
      end
      if (link.s_valid && link.s_ready) begin
        hs_total <= hs_total + 1;
        hs_cyc   <= cyc;
      end
    end
  end

  // NPU responder: raises result_valid npu_delay cycles after the start pulse (never if <= 0).
  int         npu_delay = 0;
  logic [7:0] npu_result = '0;
  int         cd = 0;
  logic       rv = 1'b0;
  int         rv_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      cd <= 0;
      rv <= 1'b0;
    end else begin
      rv <= 1'b0;
      if (npu_uio_in[1] && npu_delay > 0) begin
        cd <= npu_delay;
      end else if (cd > 0) begin
        cd <= cd - 1;
        if (cd == 1) begin
          rv     <= 1'b1;
          rv_cyc <= cyc;
        end
      end
    end
  end

  assign npu_uo_out  = rv ? npu_result : 8'hFF;
  assign npu_uio_out = {5'b11111, rv, 2'b11};

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_s_ready"},   link.s_ready,   0);
    checkOutput({tag, "_m_valid"},   link.m_valid,   0);
    checkOutput({tag, "_m_data"},    link.m_data,    0);
    checkOutput({tag, "_m_timeout"}, link.m_timeout, 0);
    checkOutput({tag, "_busy"},      busy,           1);
    checkOutput({tag, "_ui_in"},     npu_ui_in,      0);
    checkOutput({tag, "_uio_in"},    npu_uio_in,     0);
    checkOutput({tag, "_ena"},       npu_ena,        0);
    checkOutput({tag, "_rst_n"},     npu_rst_n,      0);
  endtask

  task automatic checkRstHold(input string tag);
    int n = 0;
    @(negedge clk);
    while (!npu_rst_n && n < 50) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, "_hold_cycles"}, n, RST_HOLD);
    checkOutput({tag, "_ena"}, npu_ena, 1);
    checkOutput({tag, "_s_ready"}, link.s_ready, 1);
    @(posedge clk);
    #1;
  endtask

  // Presents one byte and returns #1 after the accepting edge, leaving s_valid high.
  task automatic applyStimulus(input logic [7:0] d, input logic l);
    int n = 0;
    link.s_valid = 1'b1;
    link.s_data  = d;
    link.s_last  = l;
    @(negedge clk);
    while (!link.s_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!link.s_ready) checkOutput("accept_bound", link.s_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic dropValid();
    link.s_valid = 1'b0;
    link.s_last  = 1'b0;
  endtask

  int mval_cyc = 0;
  int ack_cyc  = 0;

  // Waits (bounded) for m_valid and compares against the scoreboard head; ends on a negedge.
  task automatic waitResult(input string tag, input int bound);
    result_t e;
    int n = 0;
    @(negedge clk);
    while (!link.m_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    mval_cyc = cyc;
    checkOutput({tag, "_m_valid"}, link.m_valid, 1);
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_scoreboard"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, "_m_data"}, link.m_data, e.data);
      checkOutput({tag, "_m_timeout"}, link.m_timeout, e.timeout);
    end
  endtask

  task automatic ackResult();
    link.m_ready = 1'b1;
    @(posedge clk);
    #1;
    link.m_ready = 1'b0;
    ack_cyc = cyc;
  endtask

  task automatic checkStrobe(input string tag, input logic [7:0] d);
    strobe_t s;
    if (strobe_q.size() == 0) begin
      checkOutput({tag, "_present"}, strobe_q.size(), 1);
    end else begin
      s = strobe_q.pop_front();
      checkOutput({tag, "_len"}, s.len, STROBE_CYCLES);
      checkOutput({tag, "_data"}, s.data, d);
      checkOutput({tag, "_stable"}, s.stable, 1);
    end
  endtask

  int s0, t0, h0, bad;

  initial begin
    link.s_valid = 1'b0;
    link.s_data  = '0;
    link.s_last  = 1'b0;
    link.m_ready = 1'b0;

    // Reset for three edges, then the NPU reset hold.
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkRstHold("post_reset");

    // Single byte command.
    npu_delay  = 10;
    npu_result = 8'h3C;
    exp_q.push_back('{8'h3C, 1'b0});
    s0 = start_cnt;
    applyStimulus(8'h5A, 1'b1);
    dropValid();
    waitResult("single", 200);
    checkOutput("single_starts", start_cnt - s0, 1);
    checkOutput("single_start_latency", start_cyc - hs_cyc, 4);
    checkOutput("single_npu_delay", rv_cyc - start_cyc, 10);
    checkOutput("single_result_latency", mval_cyc - rv_cyc, 1);
    checkOutput("single_strobes", strobe_q.size(), 1);
    checkStrobe("single_strobe", 8'h5A);
    checkOutput("single_gaps", gap_q.size(), 0);
    ackResult();

    // Three bytes back to back; low time between strobes is the GAP plus the IDLE handshake cycle.
    npu_delay  = 3;
    npu_result = 8'h99;
    exp_q.push_back('{8'h99, 1'b0});
    s0 = start_cnt;
    t0 = strobe_total;
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h03, 1'b1);
    dropValid();
    waitResult("three", 200);
    checkOutput("three_starts", start_cnt - s0, 1);
    checkOutput("three_strobes_before_start", strobes_at_start - t0, 3);
    checkOutput("three_strobes", strobe_q.size(), 3);
    checkStrobe("three_b0", 8'h01);
    checkStrobe("three_b1", 8'h02);
    checkStrobe("three_b2", 8'h03);
    checkOutput("three_gaps", gap_q.size(), 2);
    while (gap_q.size() > 0) checkOutput("three_gap_len", gap_q.pop_front(), GAP_CYCLES + 1);
    ackResult();

    // Seventeen bytes without s_last: the sixteenth is forced last.
    npu_delay  = 5;
    npu_result = 8'h77;
    exp_q.push_back('{8'h77, 1'b0});
    s0 = start_cnt;
    t0 = strobe_total;
    h0 = hs_total;
    for (int i = 0; i < MAX_BYTES; i++) applyStimulus(8'h20 + 8'(i), 1'b0);
    link.s_data = 8'hEE;
    link.s_last = 1'b1;
    waitResult("maxbytes", 300);
    checkOutput("maxbytes_starts", start_cnt - s0, 1);
    checkOutput("maxbytes_strobes_before_start", strobes_at_start - t0, MAX_BYTES);
    checkOutput("maxbytes_accepted_before_result", hs_total - h0, MAX_BYTES);
    checkOutput("maxbytes_s_ready_in_result", link.s_ready, 0);
    strobe_q.delete();
    gap_q.delete();
    npu_delay  = 2;
    npu_result = 8'h42;
    exp_q.push_back('{8'h42, 1'b0});
    ackResult();
    applyStimulus(8'hEE, 1'b1);
    dropValid();
    checkOutput("byte17_accept_cycle", hs_cyc - ack_cyc, 0);
    checkOutput("byte17_accepted", hs_total - h0, MAX_BYTES + 1);
    waitResult("byte17", 200);
    checkStrobe("byte17_strobe", 8'hEE);
    ackResult();

    // NPU never answers.
    npu_delay = 0;
    exp_q.push_back('{8'h00, 1'b1});
    applyStimulus(8'h33, 1'b1);
    dropValid();
    waitResult("timeout", TIMEOUT + 200);
    checkOutput("timeout_latency", mval_cyc - start_cyc, TIMEOUT + 1);
    ackResult();
    strobe_q.delete();

    // Result held while the consumer stalls.
    npu_delay  = 4;
    npu_result = 8'hA5;
    exp_q.push_back('{8'hA5, 1'b0});
    applyStimulus(8'h44, 1'b1);
    dropValid();
    waitResult("stall", 200);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (link.m_data !== 8'hA5 || link.m_timeout !== 1'b0 ||
          link.s_ready !== 1'b0 || link.m_valid !== 1'b1) bad++;
    end
    checkOutput("stall_violations", bad, 0);
    ackResult();
    strobe_q.delete();

    // Reset while waiting for the NPU.
    npu_delay = 0;
    applyStimulus(8'h55, 1'b1);
    dropValid();
    repeat (6) @(posedge clk);
    #1;
    checkOutput("wait_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkResetValues("mid_reset");
    rst = 1'b0;
    checkRstHold("mid_reset_release");
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
